cfg_mgmt_access_arb: RTL

Synthesizable, parametrised configuration-management access engine for the RP/EP cfg_mgmt port. NUM_REQ independent requesters (test sequencers, link-init FSM, error handler) share one cfg_mgmt interface through round-robin arbitration. Each access runs one read or write, waits for cfg_mgmt_read_write_done with a timeout, then returns a response to the granted requester. Sits between user logic and the PCIe core cfg_mgmt port.

---
 rtl/cfg_mgmt_access_arb.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/cfg_mgmt_access_arb.sv
// ---------------------------------------------------------------------------
// cfg_mgmt_access_arb
//
// Purpose: shares one PCIe core cfg_mgmt port between NUM_REQ requesters.
// Requests are granted round-robin. Each granted access drives one read or
// write strobe to the core and waits for cfg_mgmt_read_write_done, bounded
// by TIMEOUT_CYC cycles. A single-cycle response then goes back to the
// owning requester, followed by GAP_CYC idle cycles.
//
// Optional feature macro: CFG_MGMT_RETRY_EN
//   When it is defined, a timed-out access is retried up to MAX_RETRY times.
//   Between attempts the strobe is low for exactly one cycle. When it is
//   undefined, the first timeout is final.
//
// Ports:
//   user_clk, user_reset          clock and asynchronous active-high reset
//   req_valid/req_ready           per-channel request and one-cycle accept pulse
//   req_write/req_type1           per-channel access kind
//   req_addr/req_wdata/req_be     packed per-channel fields; channel i is
//                                 held at [i*W +: W]
//   rsp_valid/rsp_rdata/rsp_err   one-cycle response to the owning channel
//   cfg_mgmt_*                    core-side cfg_mgmt interface
//   busy                          high whenever the engine is not idle
//   timeout_count                 saturating count of final timeouts
// ---------------------------------------------------------------------------
module cfg_mgmt_access_arb #(
    parameter int NUM_REQ     = 4,
    parameter int ADDR_W      = 10,
    parameter int TIMEOUT_CYC = 256,
    parameter int GAP_CYC     = 2,
    parameter int MAX_RETRY   = 2
) (
    input  logic                      user_clk,
    input  logic                      user_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ-1:0]        req_type1,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]     req_wdata,
    input  logic [NUM_REQ*4-1:0]      req_be,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         cfg_mgmt_addr,
    output logic                      cfg_mgmt_write,
    output logic [31:0]               cfg_mgmt_write_data,
    output logic [3:0]                cfg_mgmt_byte_enable,
    output logic                      cfg_mgmt_read,
    output logic                      cfg_mgmt_type1_cfg_reg_access,
    input  logic [31:0]               cfg_mgmt_read_data,
    input  logic                      cfg_mgmt_read_write_done,
    output logic                      busy,
    output logic [15:0]               timeout_count
);

    localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W   = $clog2(TIMEOUT_CYC);
    localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RESP, S_GAP, S_RETRY} state_t;

    state_t            state_reg;
    logic [PTR_W-1:0]  rr_ptr_reg;   // first channel to search next time (last_grant+1)
    logic [PTR_W-1:0]  grant_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic [GAP_W-1:0]  gap_cnt_reg;

    logic [ADDR_W-1:0] addr_ch  [NUM_REQ];
    logic [31:0]       wdata_ch [NUM_REQ];
    logic [3:0]        be_ch    [NUM_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_ch[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_ch[gi] = req_wdata[gi*32 +: 32];
            assign be_ch[gi]    = req_be[gi*4 +: 4];
        end
    endgenerate

    // Round-robin pick: scan from rr_ptr_reg upwards with wrap-around. The loop
    // runs backwards so that the match closest to the pointer is written last.
    logic [PTR_W-1:0] grant_idx;
    logic             grant_found;
    logic [PTR_W:0]   idx_wide;
    logic [PTR_W-1:0] idx;

    always_comb begin
        grant_idx   = '0;
        grant_found = 1'b0;
        idx_wide    = '0;
        idx         = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx_wide = {1'b0, rr_ptr_reg} + (PTR_W+1)'(i);
            if (idx_wide >= (PTR_W+1)'(NUM_REQ))
                idx_wide = idx_wide - (PTR_W+1)'(NUM_REQ);
            idx = idx_wide[PTR_W-1:0];
            if (req_valid[idx]) begin
                grant_idx   = idx;
                grant_found = 1'b1;
            end
        end
    end

    logic [PTR_W-1:0] next_ptr;
    assign next_ptr = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

    logic accept;
    assign accept = (state_reg == S_IDLE) && grant_found && !user_reset;

    logic done_hit, timeout_hit, retry_left;
    assign done_hit    = (state_reg == S_WAIT) && cfg_mgmt_read_write_done;
    assign timeout_hit = (state_reg == S_WAIT) && !cfg_mgmt_read_write_done &&
                         (wait_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));

`ifdef CFG_MGMT_RETRY_EN
    logic [RETRY_W-1:0] retry_cnt_reg;
    logic               op_write_reg;   // direction to re-assert on a retry

    assign retry_left = (retry_cnt_reg != RETRY_W'(MAX_RETRY));

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            retry_cnt_reg <= '0;
            op_write_reg  <= 1'b0;
        end else if (accept) begin
            retry_cnt_reg <= '0;
            op_write_reg  <= req_write[grant_idx];
        end else if (timeout_hit && retry_left) begin
            retry_cnt_reg <= retry_cnt_reg + 1'b1;
        end
    end
`else
    assign retry_left = 1'b0;
`endif

    // Accept and response pulses are decoded from the registered state and grant.
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (accept)
            req_ready[grant_idx] = 1'b1;
        if (state_reg == S_RESP)
            rsp_valid[grant_reg] = 1'b1;
    end

    assign busy = (state_reg != S_IDLE);

    always_ff @(posedge user_clk or posedge user_reset) begin
        if (user_reset) begin
            state_reg                     <= S_IDLE;
            rr_ptr_reg                    <= '0;
            grant_reg                     <= '0;
            wait_cnt_reg                  <= '0;
            gap_cnt_reg                   <= '0;
            rsp_rdata                     <= '0;
            rsp_err                       <= 1'b0;
            cfg_mgmt_addr                 <= '0;
            cfg_mgmt_write                <= 1'b0;
            cfg_mgmt_write_data           <= '0;
            cfg_mgmt_byte_enable          <= '0;
            cfg_mgmt_read                 <= 1'b0;
            cfg_mgmt_type1_cfg_reg_access <= 1'b0;
            timeout_count                 <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (grant_found) begin
                        grant_reg                     <= grant_idx;
                        rr_ptr_reg                    <= next_ptr;
                        cfg_mgmt_addr                 <= addr_ch[grant_idx];
                        cfg_mgmt_write_data           <= wdata_ch[grant_idx];
                        cfg_mgmt_byte_enable          <= be_ch[grant_idx];
                        cfg_mgmt_type1_cfg_reg_access <= req_type1[grant_idx];
                        cfg_mgmt_write                <= req_write[grant_idx];
                        cfg_mgmt_read                 <= !req_write[grant_idx];
                        wait_cnt_reg                  <= '0;
                        state_reg                     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // done takes priority over a timeout seen in the same cycle
                    if (done_hit) begin
                        cfg_mgmt_write       <= 1'b0;
                        cfg_mgmt_read        <= 1'b0;
                        cfg_mgmt_addr        <= '0;
                        cfg_mgmt_byte_enable <= '0;
                        cfg_mgmt_write_data  <= '0;
                        rsp_rdata            <= cfg_mgmt_read ? cfg_mgmt_read_data : 32'd0;
                        rsp_err              <= 1'b0;
                        state_reg            <= S_RESP;
                    end else if (timeout_hit) begin
                        cfg_mgmt_write <= 1'b0;
                        cfg_mgmt_read  <= 1'b0;
                        wait_cnt_reg   <= '0;
                        if (retry_left) begin
                            // fields stay in place for the next attempt
                            state_reg <= S_RETRY;
                        end else begin
                            cfg_mgmt_addr        <= '0;
                            cfg_mgmt_byte_enable <= '0;
                            cfg_mgmt_write_data  <= '0;
                            rsp_rdata            <= 32'hFFFF_FFFF;
                            rsp_err              <= 1'b1;
                            if (timeout_count != 16'hFFFF)
                                timeout_count <= timeout_count + 16'd1;
                            state_reg <= S_RESP;
                        end
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
`ifdef CFG_MGMT_RETRY_EN
                S_RETRY: begin
                    cfg_mgmt_write <= op_write_reg;
                    cfg_mgmt_read  <= !op_write_reg;
                    wait_cnt_reg   <= '0;
                    state_reg      <= S_WAIT;
                end
`endif
                S_RESP: begin
                    gap_cnt_reg <= '0;
                    state_reg   <= (GAP_CYC == 0) ? S_IDLE : S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt_reg == GAP_W'(GAP_CYC - 1))
                        state_reg <= S_IDLE;
                    else
                        gap_cnt_reg <= gap_cnt_reg + 1'b1;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

endmodule
